// File: rtl/circle_motion_ctrl_if.sv
// Bundle between the circle motion controller and the VGA paint/timing stage.
// The controller (master) receives vertical sync and the run enable, and
// presents the registered circle centre with its update/bounce strobes.
interface circle_motion_ctrl_if;
    logic       VGA_VS;     // active-low vertical sync from the paint stage
    logic       Run;        // 1 = motion enabled, 0 = frozen
    logic [9:0] Center_X;   // registered X centre
    logic [9:0] Center_Y;   // registered Y centre
    logic       Update;     // one-cycle pulse when a new centre is committed
    logic       Bounce_X;   // one-cycle pulse with Update when X reversed
    logic       Bounce_Y;   // one-cycle pulse with Update when Y reversed
    logic [1:0] Color_Idx;  // bounce colour index

    modport master (
        input  VGA_VS, Run,
        output Center_X, Center_Y, Update, Bounce_X, Bounce_Y, Color_Idx
    );

    modport slave (
        output VGA_VS, Run,
        input  Center_X, Center_Y, Update, Bounce_X, Bounce_Y, Color_Idx
    );
endinterface

// File: rtl/circle_motion_ctrl.sv
// circle_motion_ctrl: frame-rate motion controller for the VGA circle display.
// Detects the falling edge of VGA_VS, advances the circle centre once every
// FRAME_DIV frames by STEP pixels per axis and bounces it off the active-area
// limits (RADIUS pixels inside each edge).
// Optional feature: define CIRCLE_COLOR_CYCLE_EN to make Color_Idx advance
// (mod 4) on every committed move that bounced; otherwise Color_Idx is 0.
module circle_motion_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int RADIUS    = 20,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 1,
    parameter int X_INIT    = 320,
    parameter int Y_INIT    = 240
) (
    input  logic                  Clk_50MHz,
    input  logic                  Rst_N,
    circle_motion_ctrl_if.master  bus
);

    localparam logic [10:0] X_MIN  = 11'(RADIUS);
    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - 1 - RADIUS);
    localparam logic [10:0] Y_MIN  = 11'(RADIUS);
    localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - 1 - RADIUS);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam int          CNT_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CALC    = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    state_t           state_q;
    logic             vs_meta_q, vs_sync_q, vs_dly_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [9:0]       cx_q, cy_q;       // committed centre
    logic [9:0]       nx_q, ny_q;       // centre computed in CALC, loaded in COMMIT
    logic             dir_x_q, dir_y_q; // 1 = moving in + direction
    logic             flag_x_q, flag_y_q;
    logic             update_q, bounce_x_q, bounce_y_q;
    logic [10:0]      calc_x_d, calc_y_d;
    logic             hit_x_d, hit_y_d;
    logic             tick;

    // Falling edge of the synchronised sync signal marks a new frame.
    assign tick = vs_dly_q & ~vs_sync_q;

    // Bring VGA_VS into this clock domain and keep a delayed copy for edge detection.
    always_ff @(posedge Clk_50MHz or negedge Rst_N) begin
        if (!Rst_N) begin
            vs_meta_q <= 1'b1;
            vs_sync_q <= 1'b1;
            vs_dly_q  <= 1'b1;
        end else begin
            vs_meta_q <= bus.VGA_VS;
            vs_sync_q <= vs_meta_q;
            vs_dly_q  <= vs_sync_q;
        end
    end

    // Next centre per axis: saturate at the limit and flag a bounce instead of wrapping.
    always_comb begin
        calc_x_d = {1'b0, cx_q};
        calc_y_d = {1'b0, cy_q};
        hit_x_d  = 1'b0;
        hit_y_d  = 1'b0;
        if (dir_x_q) begin
            if ({1'b0, cx_q} + STEP_W > X_MAX) begin
                calc_x_d = X_MAX;
                hit_x_d  = 1'b1;
            end else begin
                calc_x_d = {1'b0, cx_q} + STEP_W;
            end
        end else begin
            if ({1'b0, cx_q} < X_MIN + STEP_W) begin
                calc_x_d = X_MIN;
                hit_x_d  = 1'b1;
            end else begin
                calc_x_d = {1'b0, cx_q} - STEP_W;
            end
        end
        if (dir_y_q) begin
            if ({1'b0, cy_q} + STEP_W > Y_MAX) begin
                calc_y_d = Y_MAX;
                hit_y_d  = 1'b1;
            end else begin
                calc_y_d = {1'b0, cy_q} + STEP_W;
            end
        end else begin
            if ({1'b0, cy_q} < Y_MIN + STEP_W) begin
                calc_y_d = Y_MIN;
                hit_y_d  = 1'b1;
            end else begin
                calc_y_d = {1'b0, cy_q} - STEP_W;
            end
        end
    end

`ifdef CIRCLE_COLOR_CYCLE_EN
    logic [1:0] color_q;

    // Colour index steps once per committed move that bounced on either axis.
    always_ff @(posedge Clk_50MHz or negedge Rst_N) begin
        if (!Rst_N) begin
            color_q <= 2'd0;
        end else if (state_q == COMMIT && (flag_x_q || flag_y_q)) begin
            color_q <= color_q + 2'd1;
        end
    end

    assign bus.Color_Idx = color_q;
`else
    assign bus.Color_Idx = 2'd0;
`endif

    // Motion FSM: count frames, compute the move, then commit it with registered strobes.
    always_ff @(posedge Clk_50MHz or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            cx_q        <= 10'(X_INIT);
            cy_q        <= 10'(Y_INIT);
            nx_q        <= 10'(X_INIT);
            ny_q        <= 10'(Y_INIT);
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            flag_x_q    <= 1'b0;
            flag_y_q    <= 1'b0;
            update_q    <= 1'b0;
            bounce_x_q  <= 1'b0;
            bounce_y_q  <= 1'b0;
        end else begin
            update_q   <= 1'b0;
            bounce_x_q <= 1'b0;
            bounce_y_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q <= WAIT_VS;
                end
                WAIT_VS: begin
                    // Frozen: forget partial frame counts but keep directions.
                    if (!bus.Run) begin
                        frame_cnt_q <= '0;
                    end else if (tick) begin
                        if (frame_cnt_q == CNT_LAST) begin
                            frame_cnt_q <= '0;
                            state_q     <= CALC;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end
                end
                CALC: begin
                    nx_q     <= calc_x_d[9:0];
                    ny_q     <= calc_y_d[9:0];
                    flag_x_q <= hit_x_d;
                    flag_y_q <= hit_y_d;
                    if (hit_x_d) dir_x_q <= ~dir_x_q;
                    if (hit_y_d) dir_y_q <= ~dir_y_q;
                    state_q  <= COMMIT;
                end
                COMMIT: begin
                    cx_q       <= nx_q;
                    cy_q       <= ny_q;
                    update_q   <= 1'b1;
                    bounce_x_q <= flag_x_q;
                    bounce_y_q <= flag_y_q;
                    state_q    <= WAIT_VS;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.Center_X = cx_q;
    assign bus.Center_Y = cy_q;
    assign bus.Update   = update_q;
    assign bus.Bounce_X = bounce_x_q;
    assign bus.Bounce_Y = bounce_y_q;

endmodule

// File: doc/circle_motion_ctrl.md
# circle_motion_ctrl

Frame-rate motion controller for the VGA circle display. Sits directly upstream of the VGA paint/timing stage: it watches that stage's vertical sync, advances a circle centre once per N frames, bounces it off the 640x480 active-area edges, and presents registered centre coordinates for the paint stage to compare against its scan counters. Optional colour-cycle index changes on every bounce.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- RADIUS, 20, circle radius in pixels; sets bounce limits
- STEP, 2, pixels moved per axis per update (>=1)
- FRAME_DIV, 1, frames per position update (>=1)
- X_INIT, 320, reset X centre; Y_INIT, 240, reset Y centre (must lie within the limits below)

Ports:
- Clk_50MHz  in  1  system clock
- Rst_N  in  1  reset; asynchronous assert, active-low; one clock, async active-low reset
- VGA_VS  in  1  active-low vertical sync from paint stage (asynchronous-safe input)
- Run  in  1  1 = motion enabled, 0 = frozen
- Center_X  out  10  registered X centre
- Center_Y  out  10  registered Y centre
- Update  out  1  one-cycle pulse when new centre committed
- Bounce_X, Bounce_Y  out  1  one-cycle pulses, coincident with Update, when that axis reversed
- Color_Idx  out  2  bounce colour index

## Operation
- Limits: X_MIN=RADIUS, X_MAX=H_ACTIVE-1-RADIUS (619), Y_MIN=RADIUS, Y_MAX=V_ACTIVE-1-RADIUS (459).
- VGA_VS through 2-flop synchroniser plus delay flop (all reset to 1); frame tick = delayed 1 and synchronised 0 (falling edge).
- Frame counter 0..FRAME_DIV-1: increments on each tick while Run=1, wraps to 0; held at 0 while Run=0. Move request = tick, Run=1, counter==FRAME_DIV-1.
- FSM: IDLE -> WAIT_VS (unconditional, one cycle after reset release); WAIT_VS -> CALC on move request; CALC -> COMMIT; COMMIT -> WAIT_VS.
- CALC, 11-bit unsigned arithmetic, no wrap: dir +: if x+STEP > X_MAX then next=X_MAX, flip dir, flag bounce; else next=x+STEP. dir -: if x < X_MIN+STEP then next=X_MIN, flip, flag; else next=x-STEP. Y identical with Y limits.
- COMMIT: load Center_X/Y, pulse Update, pulse Bounce_X/Bounce_Y per flags.
- Corner hit: both bounce pulses same cycle; Color_Idx advances by 1 only.
- Ticks arriving in IDLE/CALC/COMMIT dropped and not counted.
- Run deassert between updates: no further motion; direction and counter retained except counter forced to 0.

## Timing
- Reset values: Center_X=X_INIT, Center_Y=Y_INIT, both directions +, Update=Bounce_X=Bounce_Y=0, Color_Idx=0, counter=0, state IDLE.
- Edge N = first Clk_50MHz rising edge capturing VGA_VS=0 in stage 1. Tick high in cycle after N+1; FSM enters CALC at N+2, COMMIT at N+3; outputs and Update/Bounce pulses registered at N+4, high exactly one cycle.
- Outputs change only at COMMIT edge; stable for whole frame otherwise.
- Rst_N low at any point (incl. CALC/COMMIT): all registers to reset values immediately, no pulse emitted.

## Configuration
- CIRCLE_COLOR_CYCLE_EN defined: Color_Idx increments (mod 4) at each COMMIT with any bounce flag set.
- Undefined: Color_Idx tied to 0, no increment logic synthesised; all else unchanged.

## Test plan
- Reset, Run=1, defaults; one VS low pulse -> Update high one cycle at N+4; Center_X=322, Center_Y=242; no bounce pulses.
- Run=0, three VS pulses -> no Update; centre stays 320/240.
- X_INIT=618, Y_INIT=240; two frames -> X=619 with Bounce_X=1, then X=617 with Bounce_X=0.
- X_INIT=618, Y_INIT=458; one frame -> X=619, Y=459, Bounce_X=Bounce_Y=1 same cycle; Color_Idx 0->1 with CIRCLE_COLOR_CYCLE_EN, stays 0 without.
- FRAME_DIV=3, Run=1, six VS pulses -> exactly two Updates, after pulses 3 and 6; centre 322/242 then 324/244.
- Rst_N low during CALC -> outputs immediately 320/240, Update never pulses; release, next VS -> normal 322/242 update.
